// File: rtl/auth_rx.sv
// auth_rx: 8N1 serial command receiver with go/stop power-authorization FSM.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   RX         asynchronous serial input, idles high
//   rider_off  high when rider weight is below threshold (clk domain)
//   rx_data    last correctly framed byte, held until the next good byte
//   rx_rdy     one-cycle pulse, rx_data just updated
//   frm_err    one-cycle pulse, stop bit sampled low and byte discarded
//   pwr_up     registered motor-drive authorization
module auth_rx #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter logic [7:0]  CMD_GO   = 8'h67,
   parameter logic [7:0]  CMD_STOP = 8'h73
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       rider_off,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frm_err,
   output logic       pwr_up
);

   localparam int unsigned CW = $clog2(BAUD_DIV);
   // Counter expires at zero, so loads are one less than the wait length.
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      AU_OFF,
      AU_PWRD,
      AU_STOPPING
   } au_state_t;

   // Receiver state
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_rdy_q, rx_rdy_d;
   logic            frm_err_q, frm_err_d;

   // Authorization state
   au_state_t       au_state_q, au_state_d;
   logic            pwr_up_q, pwr_up_d;

   logic            fall_edge;
   logic            cnt_expired;

   // rx_prev_q requires a high sample before any start, so a line left low
   // after a framing error cannot retrigger reception.
   assign fall_edge   = rx_prev_q & ~rx_sync_q;
   assign cnt_expired = (baud_cnt_q == '0);

   //------------------------------------------------------------------
   // Receiver: register
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_rdy_q   <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         rx_meta_q  <= RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_rdy_q   <= rx_rdy_d;
         frm_err_q  <= frm_err_d;
      end
   end

   //------------------------------------------------------------------
   // Receiver: next state and datapath
   //------------------------------------------------------------------
   always_comb begin
      rx_state_d = rx_state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_rdy_d   = 1'b0;
      frm_err_d  = 1'b0;

      unique case (rx_state_q)
         RX_IDLE: begin
            if (fall_edge) begin
               rx_state_d = RX_START;
               baud_cnt_d = HALF_LOAD;
            end
         end

         RX_START: begin
            if (cnt_expired) begin
               if (!rx_sync_q) begin
                  rx_state_d = RX_DATA;
                  baud_cnt_d = FULL_LOAD;
                  bit_cnt_d  = '0;
               end else begin
                  rx_state_d = RX_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         RX_DATA: begin
            if (cnt_expired) begin
               shift_d    = {rx_sync_q, shift_q[7:1]};
               baud_cnt_d = FULL_LOAD;
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         RX_STOP: begin
            if (cnt_expired) begin
               if (rx_sync_q) begin
                  rx_data_d = shift_q;
                  rx_rdy_d  = 1'b1;
               end else begin
                  frm_err_d = 1'b1;
               end
               rx_state_d = RX_IDLE;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         default: rx_state_d = RX_IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // Authorization FSM: state register
   //------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         au_state_q <= AU_OFF;
         pwr_up_q   <= 1'b0;
      end else begin
         au_state_q <= au_state_d;
         pwr_up_q   <= pwr_up_d;
      end
   end

   //------------------------------------------------------------------
   // Authorization FSM: next state (commands are only rx_rdy bytes)
   //------------------------------------------------------------------
   always_comb begin
      au_state_d = au_state_q;
      unique case (au_state_q)
         AU_OFF: begin
            if (rx_rdy_q && rx_data_q == CMD_GO) au_state_d = AU_PWRD;
         end

         AU_PWRD: begin
            if (rx_rdy_q && rx_data_q == CMD_STOP)
               au_state_d = rider_off ? AU_OFF : AU_STOPPING;
         end

         AU_STOPPING: begin
            // A go command outranks a simultaneous rider_off.
            if (rx_rdy_q && rx_data_q == CMD_GO) au_state_d = AU_PWRD;
            else if (rider_off)                  au_state_d = AU_OFF;
         end

         default: au_state_d = AU_OFF;
      endcase
   end

   //------------------------------------------------------------------
   // Authorization FSM: output decode of the next state
   //------------------------------------------------------------------
   always_comb begin
      pwr_up_d = (au_state_d != AU_OFF);
   end

   assign rx_data = rx_data_q;
   assign rx_rdy  = rx_rdy_q;
   assign frm_err = frm_err_q;
   assign pwr_up  = pwr_up_q;

endmodule

// File: tb/tb_auth_rx.sv
// tb_auth_rx: bench for auth_rx with BAUD_DIV=16. Table-driven frames,
// hand-written multi-cycle corner sequences and randomized frames checked
// against a behavioural authorization model.
module tb_auth_rx;

   localparam int BD     = 16;
   // Pin falls at negedge of cycle k0; sync sees it at k0+2; stop sample at
   // k0+2+BD/2+9*BD; pulse one cycle later.
   localparam int EV_LAT = 3 + BD / 2 + 9 * BD;
   localparam logic [7:0] GO   = 8'h67;
   localparam logic [7:0] STOP = 8'h73;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX = 1'b1;
   logic       rider_off = 1'b0;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       frm_err;
   logic       pwr_up;

   auth_rx #(
      .BAUD_DIV (BD),
      .CMD_GO   (GO),
      .CMD_STOP (STOP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .rider_off (rider_off),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .frm_err   (frm_err),
      .pwr_up    (pwr_up)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } ev_t;

   ev_t rdy_ev[$];
   int  ferr_ev[$];
   bit  pwr_hist [0:32767];

   always @(negedge clk) begin
      if (rx_rdy === 1'b1) rdy_ev.push_back('{cyc, rx_data});
      if (frm_err === 1'b1) ferr_ev.push_back(cyc);
      if (cyc < 32768) pwr_hist[cyc] = (pwr_up === 1'b1);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Starts at a negedge, ends at a negedge with the line high.
   // jit stretches/shrinks every odd-numbered bit by one clock (~3% skew).
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int jit,
                             output int k0);
      logic [9:0] bits;
      k0   = cyc;
      bits = {stop_ok, d, 1'b0};
      for (int unsigned k = 0; k < 10; k++) begin
         RX = bits[k];
         repeat ((k % 2 == 1) ? BD + jit : BD) @(negedge clk);
      end
      RX = 1'b1;
   endtask

   task automatic check_frame(input int k0, input bit exp_rdy, input logic [7:0] exp_data,
                              input bit pwr_old, input bit pwr_new);
      int ec;
      ec = k0 + EV_LAT;
      check("rdy_count", 32'(rdy_ev.size()), 32'(exp_rdy));
      check("ferr_count", 32'(ferr_ev.size()), 32'(!exp_rdy));
      if (exp_rdy && rdy_ev.size() > 0) begin
         check("rdy_cycle", 32'(rdy_ev[0].cyc), 32'(ec));
         check("rdy_data", 32'(rdy_ev[0].d), 32'(exp_data));
         check("pwr_at_rdy", 32'(pwr_hist[ec]), 32'(pwr_old));
         check("pwr_after_rdy", 32'(pwr_hist[ec + 1]), 32'(pwr_new));
      end
      if (!exp_rdy && ferr_ev.size() > 0) check("ferr_cycle", 32'(ferr_ev[0]), 32'(ec));
      check("rx_data_held", 32'(rx_data), 32'(exp_data));
      check("pwr_up", 32'(pwr_up), 32'(pwr_new));
      rdy_ev.delete();
      ferr_ev.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         rider;
      bit         exp_rdy;
      logic [7:0] exp_data;
      bit         exp_pwr;
   } vec_t;

   vec_t tbl[12];

   // Behavioural model: powered / waiting-for-rider-or-go.
   bit         m_on, m_wait;
   logic [7:0] m_data;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
      $fatal(1);
   end

   initial begin
      int  k0;
      bit  prev_pwr;
      bit  rd, ok, old_pwr;
      int  jit, gap;
      logic [7:0] b;

      tbl[0]  = '{8'h73, 1'b1, 1'b0, 1'b1, 8'h73, 1'b0};
      tbl[1]  = '{8'h67, 1'b1, 1'b0, 1'b1, 8'h67, 1'b1};
      tbl[2]  = '{8'h67, 1'b1, 1'b0, 1'b1, 8'h67, 1'b1};
      tbl[3]  = '{8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1};
      tbl[4]  = '{8'h73, 1'b1, 1'b0, 1'b1, 8'h73, 1'b1};
      tbl[5]  = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1};
      tbl[6]  = '{8'h67, 1'b1, 1'b0, 1'b1, 8'h67, 1'b1};
      tbl[7]  = '{8'h73, 1'b1, 1'b1, 1'b1, 8'h73, 1'b0};
      tbl[8]  = '{8'h67, 1'b0, 1'b0, 1'b0, 8'h73, 1'b0};
      tbl[9]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
      tbl[10] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
      tbl[11] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};

      // Reset state
      repeat (4) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("reset_rx_rdy", 32'(rx_rdy), 32'h0);
      check("reset_frm_err", 32'(frm_err), 32'h0);
      check("reset_pwr_up", 32'(pwr_up), 32'h0);
      rst = 1'b0;
      idle(6);
      check("post_reset_events", 32'(rdy_ev.size() + ferr_ev.size()), 32'h0);
      check("post_reset_pwr_up", 32'(pwr_up), 32'h0);

      // Table-driven frames
      prev_pwr = 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
         rider_off = tbl[i].rider;
         send_frame(tbl[i].data, tbl[i].stop_ok, 0, k0);
         check_frame(k0, tbl[i].exp_rdy, tbl[i].exp_data, prev_pwr, tbl[i].exp_pwr);
         prev_pwr = tbl[i].exp_pwr;
         idle(2);
      end

      // Short low glitch, then a real byte
      RX = 1'b0;
      repeat (4) @(negedge clk);
      idle(40);
      check("glitch_rdy", 32'(rdy_ev.size()), 32'h0);
      check("glitch_ferr", 32'(ferr_ev.size()), 32'h0);
      check("glitch_rx_data", 32'(rx_data), 32'hFF);
      send_frame(8'hA5, 1'b1, 0, k0);
      check_frame(k0, 1'b1, 8'hA5, 1'b0, 1'b0);
      idle(2);

      // STOPPING, then rider_off rises: pwr_up drops exactly one cycle later
      send_frame(GO, 1'b1, 0, k0);
      check_frame(k0, 1'b1, GO, 1'b0, 1'b1);
      send_frame(STOP, 1'b1, 0, k0);
      check_frame(k0, 1'b1, STOP, 1'b1, 1'b1);
      idle(5);
      check("stopping_pwr_up", 32'(pwr_up), 32'h1);
      rider_off = 1'b1;
      #1;
      check("rider_no_early_drop", 32'(pwr_up), 32'h1);
      @(negedge clk);
      check("rider_drop_latency", 32'(pwr_up), 32'h0);
      rider_off = 1'b0;
      idle(3);

      // STOPPING with GO arriving in the same cycle as rider_off: GO wins
      send_frame(GO, 1'b1, 0, k0);
      check_frame(k0, 1'b1, GO, 1'b0, 1'b1);
      send_frame(STOP, 1'b1, 0, k0);
      check_frame(k0, 1'b1, STOP, 1'b1, 1'b1);
      fork
         send_frame(GO, 1'b1, 0, k0);
         begin
            repeat (EV_LAT) @(negedge clk);
            rider_off = 1'b1;
         end
      join
      check_frame(k0, 1'b1, GO, 1'b1, 1'b1);
      idle(4);
      check("go_wins_pwr_held", 32'(pwr_up), 32'h1);
      send_frame(STOP, 1'b1, 0, k0);
      check_frame(k0, 1'b1, STOP, 1'b1, 1'b0);
      rider_off = 1'b0;
      idle(2);

      // Baud skew, slow then fast, back to back
      send_frame(GO, 1'b1, 1, k0);
      check_frame(k0, 1'b1, GO, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b1, -1, k0);
      idle(4);
      check_frame(k0, 1'b1, 8'h3C, 1'b1, 1'b1);

      // Reset mid-byte after sample 4
      k0 = cyc;
      b  = 8'hC3;
      RX = 1'b0;
      repeat (BD) @(negedge clk);
      for (int unsigned k = 0; k < 4; k++) begin
         RX = b[k];
         repeat (BD) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("midbyte_rst_rx_data", 32'(rx_data), 32'h0);
      check("midbyte_rst_rx_rdy", 32'(rx_rdy), 32'h0);
      check("midbyte_rst_frm_err", 32'(frm_err), 32'h0);
      check("midbyte_rst_pwr_up", 32'(pwr_up), 32'h0);
      RX = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rdy_ev.delete();
      ferr_ev.delete();
      idle(BD * 10);
      check("midbyte_no_pulse", 32'(rdy_ev.size() + ferr_ev.size()), 32'h0);
      send_frame(GO, 1'b1, 0, k0);
      check_frame(k0, 1'b1, GO, 1'b0, 1'b1);
      idle(2);

      // Randomized frames against the behavioural model
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(3);
      rdy_ev.delete();
      ferr_ev.delete();
      m_on = 1'b0;
      m_wait = 1'b0;
      m_data = 8'h00;
      for (int unsigned n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       b = GO;
            1:       b = STOP;
            default: b = 8'($urandom);
         endcase
         ok  = ($urandom_range(0, 7) != 0);
         rd  = ($urandom_range(0, 2) == 0);
         jit = int'($urandom_range(0, 2)) - 1;
         gap = int'($urandom_range(0, 2));
         if (!ok && gap < 2) gap = 2;

         // rider_off takes effect long before the byte completes
         if (m_wait && rd) begin
            m_on   = 1'b0;
            m_wait = 1'b0;
         end
         old_pwr = m_on;
         if (ok) begin
            m_data = b;
            if (!m_on) begin
               if (b == GO) m_on = 1'b1;
            end else if (!m_wait) begin
               if (b == STOP) begin
                  if (rd) m_on = 1'b0;
                  else    m_wait = 1'b1;
               end
            end else if (b == GO) begin
               m_wait = 1'b0;
            end
         end

         rider_off = rd;
         send_frame(b, ok, jit, k0);
         if (jit < 0) idle(4);
         check_frame(k0, ok, m_data, old_pwr, m_on);
         idle(gap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
